// File: rtl/code_prog_pkg.sv
// Shared types and constants for the combination programmer:
// FSM state encoding, seven-segment patterns and slot helpers.
package code_prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEW     = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } prog_state_t;

  localparam logic [23:0] CODE_DEFAULT = 24'h281996;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Active-low glyphs for 0..F, segment g at bit 6; entry 0 is the lowest slice.
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Slot 0 is the leftmost pair of the 24-bit combination.
  function automatic logic [7:0] slotGet(input logic [23:0] code, input logic [1:0] k);
    case (k)
      2'd0:    return code[23:16];
      2'd1:    return code[15:8];
      default: return code[7:0];
    endcase
  endfunction

  function automatic logic [23:0] slotPut(input logic [23:0] code, input logic [1:0] k,
                                          input logic [7:0] pair);
    logic [23:0] result;
    result = code;
    case (k)
      2'd0:    result[23:16] = pair;
      2'd1:    result[15:8]  = pair;
      default: result[7:0]   = pair;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg7_hex.sv
// Hex digit to active-low seven-segment decoder.
module seg7_hex
  import code_prog_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_HEX_TABLE[i_digit];

endmodule

// File: rtl/code_programmer.sv
// Lock combination programmer: the user enters three BCD pairs, confirms
// them, and the new combination is committed only when both entries agree.
module code_programmer
  import code_prog_pkg::*;
#(
  parameter logic [23:0] DEFAULT_CODE = CODE_DEFAULT,
  parameter int          HOLD_CYCLES  = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  A,
  input  logic [3:0]  B,
  input  logic        enter,
  input  logic        prog_start,
  input  logic        abort,
  output logic [23:0] code_out,
  output logic        code_valid,
  output logic        busy,
  output logic        err_digit,
  output logic [6:0]  H1,
  output logic [6:0]  H2,
  output logic [6:0]  H3,
  output logic [6:0]  H4,
  output logic [6:0]  H5,
  output logic [6:0]  H6
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  prog_state_t      r_state, w_stateNext;
  logic [1:0]       r_k, w_kNext;
  logic [23:0]      r_newCode, w_newCodeNext;
  logic [23:0]      r_confCode, w_confCodeNext;
  logic             r_mismatch, w_mismatchNext;
  logic [CNT_W-1:0] r_holdCnt, w_holdCntNext;
  logic [23:0]      r_codeOut, w_codeOutNext;
  logic             r_codeValid, w_codeValidNext;
  logic             r_errDigit, w_errDigitNext;
  logic             r_enterPrev, r_progPrev;

  logic             w_enterEdge, w_progEdge, w_pairOk, w_mismatchNow;
  logic [7:0]       w_pair;
  logic [23:0]      w_dispCode;
  logic [6:0]       w_seg1, w_seg2, w_seg3, w_seg4, w_seg5, w_seg6;

  assign w_enterEdge   = enter & ~r_enterPrev;
  assign w_progEdge    = prog_start & ~r_progPrev;
  assign w_pair        = {A, B};
  assign w_pairOk      = (A <= 4'd9) && (B <= 4'd9);
  assign w_mismatchNow = r_mismatch | (w_pair != slotGet(r_newCode, r_k));

  assign code_out   = r_codeOut;
  assign code_valid = r_codeValid;
  assign err_digit  = r_errDigit;
  assign busy       = (r_state != ST_IDLE);

  // State register plus all datapath registers and the button edge history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_k         <= 2'd0;
      r_newCode   <= 24'd0;
      r_confCode  <= 24'd0;
      r_mismatch  <= 1'b0;
      r_holdCnt   <= '0;
      r_codeOut   <= DEFAULT_CODE;
      r_codeValid <= 1'b0;
      r_errDigit  <= 1'b0;
      r_enterPrev <= 1'b0;
      r_progPrev  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_k         <= w_kNext;
      r_newCode   <= w_newCodeNext;
      r_confCode  <= w_confCodeNext;
      r_mismatch  <= w_mismatchNext;
      r_holdCnt   <= w_holdCntNext;
      r_codeOut   <= w_codeOutNext;
      r_codeValid <= w_codeValidNext;
      r_errDigit  <= w_errDigitNext;
      r_enterPrev <= enter;
      r_progPrev  <= prog_start;
    end
  end

  // Next-state logic; abort beats everything, non-BCD pairs only raise err_digit.
  always_comb begin
    w_stateNext     = r_state;
    w_kNext         = r_k;
    w_newCodeNext   = r_newCode;
    w_confCodeNext  = r_confCode;
    w_mismatchNext  = r_mismatch;
    w_holdCntNext   = r_holdCnt;
    w_codeOutNext   = r_codeOut;
    w_codeValidNext = 1'b0;
    w_errDigitNext  = 1'b0;
    if (abort && (r_state != ST_IDLE)) begin
      w_stateNext   = ST_IDLE;
      w_kNext       = 2'd0;
      w_holdCntNext = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_progEdge) begin
            w_stateNext    = ST_NEW;
            w_kNext        = 2'd0;
            w_newCodeNext  = 24'd0;
            w_confCodeNext = 24'd0;
            w_mismatchNext = 1'b0;
          end
        end
        ST_NEW: begin
          if (w_enterEdge) begin
            if (!w_pairOk) begin
              w_errDigitNext = 1'b1;
            end else begin
              w_newCodeNext = slotPut(r_newCode, r_k, w_pair);
              if (r_k == 2'd2) begin
                w_stateNext    = ST_CONFIRM;
                w_kNext        = 2'd0;
                w_confCodeNext = 24'd0;
              end else begin
                w_kNext = r_k + 2'd1;
              end
            end
          end
        end
        ST_CONFIRM: begin
          if (w_enterEdge) begin
            if (!w_pairOk) begin
              w_errDigitNext = 1'b1;
            end else begin
              w_confCodeNext = slotPut(r_confCode, r_k, w_pair);
              w_mismatchNext = w_mismatchNow;
              if (r_k == 2'd2) begin
                w_kNext       = 2'd0;
                w_holdCntNext = '0;
                if (w_mismatchNow) begin
                  w_stateNext = ST_ERROR;
                end else begin
                  w_stateNext     = ST_DONE;
                  w_codeOutNext   = r_newCode;
                  w_codeValidNext = 1'b1;
                end
              end else begin
                w_kNext = r_k + 2'd1;
              end
            end
          end
        end
        ST_DONE, ST_ERROR: begin
          if (r_holdCnt == HOLD_LAST) begin
            w_stateNext   = ST_IDLE;
            w_holdCntNext = '0;
          end else begin
            w_holdCntNext = r_holdCnt + 1'b1;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_kNext     = 2'd0;
        end
      endcase
    end
  end

  assign w_dispCode = (r_state == ST_CONFIRM) ? r_confCode : r_newCode;

  seg7_hex u_seg6 (.i_digit(w_dispCode[23:20]), .o_seg(w_seg6));
  seg7_hex u_seg5 (.i_digit(w_dispCode[19:16]), .o_seg(w_seg5));
  seg7_hex u_seg4 (.i_digit(w_dispCode[15:12]), .o_seg(w_seg4));
  seg7_hex u_seg3 (.i_digit(w_dispCode[11:8]),  .o_seg(w_seg3));
  seg7_hex u_seg2 (.i_digit((r_state == ST_IDLE) ? A : w_dispCode[7:4]), .o_seg(w_seg2));
  seg7_hex u_seg1 (.i_digit((r_state == ST_IDLE) ? B : w_dispCode[3:0]), .o_seg(w_seg1));

  // Display muxing: live switches in IDLE, entered slots while programming, status glyphs on hold.
  always_comb begin
    H6 = SEG_BLANK;
    H5 = SEG_BLANK;
    H4 = SEG_BLANK;
    H3 = SEG_BLANK;
    H2 = SEG_BLANK;
    H1 = SEG_BLANK;
    case (r_state)
      ST_IDLE: begin
        H2 = w_seg2;
        H1 = w_seg1;
      end
      ST_NEW, ST_CONFIRM: begin
        if (r_k > 2'd0) begin
          H6 = w_seg6;
          H5 = w_seg5;
        end
        if (r_k > 2'd1) begin
          H4 = w_seg4;
          H3 = w_seg3;
        end
      end
      ST_DONE: begin
        H6 = SEG_ZERO;
        H5 = SEG_ZERO;
        H4 = SEG_ZERO;
        H3 = SEG_ZERO;
        H2 = SEG_ZERO;
        H1 = SEG_ZERO;
      end
      ST_ERROR: begin
        H6 = SEG_DASH;
        H5 = SEG_DASH;
        H4 = SEG_DASH;
        H3 = SEG_DASH;
        H2 = SEG_DASH;
        H1 = SEG_DASH;
      end
      default: begin
        H1 = SEG_BLANK;
      end
    endcase
  end

endmodule

// File: tb/tb_code_programmer.sv
// Directed bench for the combination programmer with a short hold time.
module tb_code_programmer;

  logic        clock;
  logic        reset;
  logic [3:0]  A;
  logic [3:0]  B;
  logic        enter;
  logic        prog_start;
  logic        abort;
  logic [23:0] code_out;
  logic        code_valid;
  logic        busy;
  logic        err_digit;
  logic [6:0]  H1, H2, H3, H4, H5, H6;

  int vectors;
  int miscompares;

  code_programmer #(.DEFAULT_CODE(24'h281996), .HOLD_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .enter(enter),
    .prog_start(prog_start), .abort(abort), .code_out(code_out),
    .code_valid(code_valid), .busy(busy), .err_digit(err_digit),
    .H1(H1), .H2(H2), .H3(H3), .H4(H4), .H5(H5), .H6(H6)
  );

  // Free-running 10 ns clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulseProg();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    tick();
  endtask

  task automatic enterRise(input logic [3:0] a, input logic [3:0] b);
    A = a;
    B = b;
    enter = 1'b1;
    tick();
  endtask

  task automatic enterFall();
    enter = 1'b0;
    tick();
  endtask

  task automatic pressPair(input logic [3:0] a, input logic [3:0] b);
    enterRise(a, b);
    enterFall();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    A = 4'd1;
    B = 4'd2;
    enter = 1'b0;
    prog_start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (code_out !== 24'h281996) begin
      miscompares++;
      $display("[TB] FAIL reset_code_out: got %h expected %h", code_out, 24'h281996);
    end
    vectors++;
    if (busy !== 1'b0 || code_valid !== 1'b0 || err_digit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got busy=%b valid=%b err=%b expected 0 0 0", busy, code_valid, err_digit);
    end
    vectors++;
    if ({H6, H5, H4, H3} !== {4{7'h7F}}) begin
      miscompares++;
      $display("[TB] FAIL reset_blank: got %h %h %h %h expected 7f each", H6, H5, H4, H3);
    end
    vectors++;
    if (H2 !== 7'h79 || H1 !== 7'h24) begin
      miscompares++;
      $display("[TB] FAIL idle_live_ab: got %h %h expected 79 24", H2, H1);
    end
  endtask

  task automatic test_program_ok();
    int holdCycles;
    pulseProg();
    vectors++;
    if (busy !== 1'b1 || H6 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL new_enter: got busy=%b H6=%h expected 1 7f", busy, H6);
    end
    pressPair(4'd1, 4'd2);
    vectors++;
    if (H6 !== 7'h79 || H5 !== 7'h24 || H4 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL new_slot0: got %h %h %h expected 79 24 7f", H6, H5, H4);
    end
    pressPair(4'd3, 4'd4);
    vectors++;
    if (H4 !== 7'h30 || H3 !== 7'h19 || H2 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL new_slot1: got %h %h %h expected 30 19 7f", H4, H3, H2);
    end
    pressPair(4'd5, 4'd6);
    vectors++;
    if (H6 !== 7'h7F || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL confirm_enter: got H6=%h busy=%b expected 7f 1", H6, busy);
    end
    pressPair(4'd1, 4'd2);
    pressPair(4'd3, 4'd4);
    vectors++;
    if (H6 !== 7'h79 || H3 !== 7'h19 || H1 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL confirm_slots: got %h %h %h expected 79 19 7f", H6, H3, H1);
    end
    enterRise(4'd5, 4'd6);
    vectors++;
    if (code_out !== 24'h123456 || code_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL commit: got code=%h valid=%b expected 123456 1", code_out, code_valid);
    end
    vectors++;
    if (H6 !== 7'h40 || H1 !== 7'h40) begin
      miscompares++;
      $display("[TB] FAIL done_zeros: got %h %h expected 40 40", H6, H1);
    end
    enterFall();
    vectors++;
    if (code_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL valid_one_cycle: got %b expected 0", code_valid);
    end
    holdCycles = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) holdCycles++;
      else break;
    end
    vectors++;
    if (holdCycles !== 8) begin
      miscompares++;
      $display("[TB] FAIL done_hold: got %0d cycles expected 8", holdCycles);
    end
    vectors++;
    if (busy !== 1'b0 || code_out !== 24'h123456) begin
      miscompares++;
      $display("[TB] FAIL done_to_idle: got busy=%b code=%h expected 0 123456", busy, code_out);
    end
  endtask

  task automatic test_mismatch();
    int holdCycles;
    bit sawValid;
    pulseProg();
    pressPair(4'd1, 4'd2);
    pressPair(4'd3, 4'd4);
    pressPair(4'd5, 4'd6);
    pressPair(4'd1, 4'd2);
    pressPair(4'd3, 4'd5);
    enterRise(4'd5, 4'd6);
    vectors++;
    if (H6 !== 7'h3F || H1 !== 7'h3F || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL error_dash: got %h %h busy=%b expected 3f 3f 1", H6, H1, busy);
    end
    sawValid = code_valid;
    enterFall();
    sawValid |= code_valid;
    holdCycles = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      sawValid |= code_valid;
      if (busy) holdCycles++;
      else break;
    end
    vectors++;
    if (holdCycles !== 8) begin
      miscompares++;
      $display("[TB] FAIL error_hold: got %0d cycles expected 8", holdCycles);
    end
    vectors++;
    if (code_out !== 24'h123456 || sawValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL error_no_commit: got code=%h valid_seen=%b expected 123456 0", code_out, sawValid);
    end
  endtask

  task automatic test_bad_digit();
    pulseProg();
    enterRise(4'hA, 4'd3);
    vectors++;
    if (err_digit !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_pulse: got %b expected 1", err_digit);
    end
    vectors++;
    if (H6 !== 7'h7F || H5 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL err_display: got %h %h expected 7f 7f", H6, H5);
    end
    enterFall();
    vectors++;
    if (err_digit !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_one_cycle: got %b expected 0", err_digit);
    end
    pressPair(4'd4, 4'd3);
    vectors++;
    if (H6 !== 7'h19 || H5 !== 7'h30 || H4 !== 7'h7F) begin
      miscompares++;
      $display("[TB] FAIL err_same_slot: got %h %h %h expected 19 30 7f", H6, H5, H4);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    pulseProg();
    pressPair(4'd1, 4'd2);
    pressPair(4'd3, 4'd4);
    abort = 1'b1;
    enterRise(4'd5, 4'd6);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || code_out !== 24'h123456) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: got busy=%b code=%h expected 0 123456", busy, code_out);
    end
    vectors++;
    if (H6 !== 7'h7F || H2 !== 7'h12 || H1 !== 7'h02) begin
      miscompares++;
      $display("[TB] FAIL abort_display: got %h %h %h expected 7f 12 02", H6, H2, H1);
    end
    enterFall();
  endtask

  task automatic test_reset_mid();
    pulseProg();
    pressPair(4'd6, 4'd5);
    pressPair(4'd4, 4'd3);
    pressPair(4'd2, 4'd1);
    pressPair(4'd6, 4'd5);
    reset = 1'b1;
    #2;
    vectors++;
    if (code_out !== 24'h281996 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async: got code=%h busy=%b expected 281996 0", code_out, busy);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (code_valid !== 1'b0 || busy !== 1'b0 || code_out !== 24'h281996) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_after: got valid=%b busy=%b code=%h expected 0 0 281996", code_valid, busy, code_out);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_program_ok();
    test_mismatch();
    test_bad_digit();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/code_programmer.md
CODE_PROGRAMMER -- requirements
Module: code_programmer

Interface
REQ-001 Parameter DEFAULT_CODE, 24'h281996, combination loaded at reset as three BCD pairs {A0,B0,A1,B1,A2,B2}.
REQ-002 Parameter HOLD_CYCLES, 50_000_000, DONE/ERROR display hold time in clocks.
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 A  input  4  tens digit of the current pair, switch level.
REQ-006 B  input  4  units digit of the current pair, switch level.
REQ-007 enter  input  1  debounced button level; its rising edge captures {A,B}.
REQ-008 prog_start  input  1  debounced button level; its rising edge starts programming.
REQ-009 abort  input  1  synchronous level; cancels programming.
REQ-010 code_out  output  24  committed combination, read by the lock checker.
REQ-011 code_valid  output  1  one-cycle pulse on commit.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err_digit  output  1  one-cycle pulse when a non-BCD pair is rejected.
REQ-014 H1..H6  output  7 each  active-low seven-segment drivers, segment g at bit 6.

Function
REQ-015 Edge detection shall register enter and prog_start each cycle; an edge is current=1 and previous=0.
REQ-016 States shall be IDLE, NEW, CONFIRM, DONE and ERROR, with a 2-bit pair index k in the range 0..2.
REQ-017 IDLE plus a prog_start edge shall go to NEW with k=0, clear new_code and clear the mismatch flag; prog_start edges outside IDLE shall be ignored.
REQ-018 NEW plus an enter edge with A<=9 and B<=9 shall store {A,B} in slot k and increment k; after slot 2 the block shall go to CONFIRM with k=0.
REQ-019 CONFIRM plus an enter edge with a BCD pair shall compare {A,B} against slot k and OR any mismatch into the flag; after slot 2 it shall go to DONE if there is no mismatch, otherwise to ERROR.
REQ-020 Any enter edge with A>9 or B>9 in NEW or CONFIRM shall be ignored (k and state unchanged) and err_digit shall pulse for one cycle.
REQ-021 On the clock edge that transitions CONFIRM to DONE, code_out shall load new_code and code_valid shall be high for exactly the following cycle.
REQ-022 DONE and ERROR shall hold for HOLD_CYCLES clocks and then return to IDLE; enter and prog_start edges shall be ignored during the hold.
REQ-023 abort=1 in any non-IDLE state shall return to IDLE next cycle with code_out unchanged; if abort and an enter edge occur in the same cycle, abort wins.
REQ-024 code_out shall change only per REQ-021 or on reset.
REQ-025 Display in IDLE: H2/H1 shall show live A/B, and H6..H3 shall be blank (7'h7F).
REQ-026 Display in NEW/CONFIRM: H6/H5 show slot0, H4/H3 show slot1, H2/H1 show slot2, using the hex table 0-F; slots not yet entered in NEW are blank, and in CONFIRM the slots shown are the confirm entries so far.
REQ-027 Display in DONE: all digits show 0 (~7'h3F); in ERROR all digits show dash (~7'h40).

Reset
REQ-028 Reset shall force state IDLE, k=0, code_out=DEFAULT_CODE, code_valid=0, err_digit=0, busy=0, hold counter=0, edge registers=0, and new_code=0.
REQ-029 Reset asserted mid-programming shall discard the partial entry, with no code_valid pulse.

Structure
REQ-030 Package code_prog_pkg shall hold the state enumeration, the seven-segment constants (blank, dash, hex table) and the DEFAULT_CODE value.
REQ-031 Sub-module seg7_hex (4-bit in, 7-bit active-low out) shall be instantiated six times, with blanking applied by output muxing.
REQ-032 The hold counter shall be sized $clog2(HOLD_CYCLES) bits.

Verification
REQ-033 Bench shall use HOLD_CYCLES=8 for the scenarios below.
REQ-034 Reset release -> code_out=24'h281996, busy=0, H6..H3=7'h7F.
REQ-035 prog_start, enter 12,34,56, then confirm 12,34,56 -> code_out=24'h123456, code_valid high for 1 cycle, DONE for 8 cycles, then IDLE.
REQ-036 NEW entries 12,34,56, confirm 12,35,56 -> ERROR (dashes) for 8 cycles, code_out unchanged, no code_valid pulse.
REQ-037 In NEW, enter A=4'hA, B=3 -> err_digit pulses, k unchanged, display unchanged; a following 43 is accepted into the same slot.
REQ-038 After two NEW entries, abort=1 in the same cycle as an enter edge -> IDLE next cycle, code_out unchanged, busy=0.
REQ-039 Reset pulse during CONFIRM k=1 -> IDLE with code_out=24'h281996, even if a prior code had been committed.
